// File: rtl/mem_access_pkg.sv
// Shared op codes, FSM states and op-decode helpers for the MEM-stage
// load/store unit (mem_access_unit, mem_lane_fmt).
package mem_access_pkg;

    typedef enum logic [2:0] {
        OP_LW  = 3'b000,
        OP_LH  = 3'b001,
        OP_LHU = 3'b010,
        OP_LB  = 3'b011,
        OP_LBU = 3'b100,
        OP_SW  = 3'b101,
        OP_SH  = 3'b110,
        OP_SB  = 3'b111
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WB   = 1'b1
    } state_e;

    function automatic logic is_store(op_e op);
        return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    endfunction

    function automatic logic is_sub_word(op_e op);
        return (op == OP_SH) || (op == OP_SB);
    endfunction

    function automatic logic is_half(op_e op);
        return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
    endfunction

    function automatic logic is_byte(op_e op);
        return (op == OP_LB) || (op == OP_LBU) || (op == OP_SB);
    endfunction

    function automatic logic is_signed(op_e op);
        return (op == OP_LH) || (op == OP_LB);
    endfunction

    // Byte offset inside the word; halves and words are force-aligned.
    function automatic logic [1:0] lane_off(op_e op, logic [1:0] a);
        if (is_byte(op)) return a;
        if (is_half(op)) return {a[1], 1'b0};
        return 2'b00;
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// Pipeline-side request/load bus plus data-memory strobes of the MEM unit.
// slave = the unit, master = pipeline and data memory.
interface mem_access_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              load_valid;
    logic [31:0]       load_data;
    logic              misalign;
    logic              dm_mem_read;
    logic              dm_mem_write;
    logic [31:0]       dm_address;
    logic [31:0]       dm_write_data;
    logic [31:0]       dm_read_data;

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, dm_read_data,
        output req_ready, load_valid, load_data, misalign,
        output dm_mem_read, dm_mem_write, dm_address, dm_write_data
    );

    modport master (
        output req_valid, req_op, req_addr, req_wdata, dm_read_data,
        input  req_ready, load_valid, load_data, misalign,
        input  dm_mem_read, dm_mem_write, dm_address, dm_write_data
    );
endinterface

// File: rtl/mem_lane_fmt.sv
// Combinational byte-lane formatter: extract+extend for loads and
// lane merge for sub-word stores. BIG_ENDIAN selects lane numbering.
module mem_lane_fmt
    import mem_access_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  op_e         i_op,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_rdata,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load,
    output logic [31:0] o_merge
);

    logic [1:0]  w_lane;
    logic [4:0]  w_sh;
    logic [31:0] w_shifted;
    logic [31:0] w_mask;
    logic        w_sx;

    // Map the byte offset to a bit position, then extract or merge there.
    always_comb begin
        w_lane    = i_off;
        if (BIG_ENDIAN) begin
            if (is_byte(i_op))      w_lane = ~i_off;
            else if (is_half(i_op)) w_lane = 2'd2 - i_off;
            else                    w_lane = 2'd0;
        end
        w_sh      = {w_lane, 3'b000};
        w_shifted = i_rdata >> w_sh;
        w_sx      = 1'b0;
        o_load    = w_shifted;
        if (is_byte(i_op)) begin
            w_sx   = is_signed(i_op) & w_shifted[7];
            o_load = {{24{w_sx}}, w_shifted[7:0]};
        end else if (is_half(i_op)) begin
            w_sx   = is_signed(i_op) & w_shifted[15];
            o_load = {{16{w_sx}}, w_shifted[15:0]};
        end
        w_mask    = is_byte(i_op) ? 32'h0000_00FF : 32'h0000_FFFF;
        w_mask    = w_mask << w_sh;
        o_merge   = (i_rdata & ~w_mask) | ((i_wdata << w_sh) & w_mask);
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store front end with 2-cycle RMW for SH/SB.
// Define MISALIGN_TRAP_EN to trap misaligned requests instead of aligning.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input logic         clk,
    input logic         rst,
    mem_access_if.slave bus
);

    state_e      r_state;
    state_e      w_state_nxt;
    logic        r_load_valid;
    logic [31:0] r_load_data;
    logic        r_misalign;
    logic [31:0] r_merge;
    logic [31:0] r_waddr;

    op_e         w_op;
    logic [31:0] w_addr32;
    logic [31:0] w_waddr;
    logic [1:0]  w_off;
    logic        w_acc;
    logic        w_mis;
    logic        w_ld_done;
    logic        w_mis_pulse;
    logic        w_rmw;
    logic [31:0] w_load;
    logic [31:0] w_merge;

    assign w_op     = op_e'(bus.req_op);
    assign w_addr32 = 32'(bus.req_addr);
    assign w_waddr  = {w_addr32[31:2], 2'b00};
    assign w_off    = lane_off(w_op, w_addr32[1:0]);
    assign w_acc    = bus.req_valid && (r_state == ST_IDLE) && !rst;

`ifdef MISALIGN_TRAP_EN
    assign w_mis = (is_half(w_op) && w_addr32[0]) ||
                   ((w_op == OP_LW || w_op == OP_SW) &&
                    (w_addr32[1:0] != 2'b00));
`else
    assign w_mis = 1'b0;
`endif

    mem_lane_fmt #(
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_fmt (
        .i_op    (w_op),
        .i_off   (w_off),
        .i_rdata (bus.dm_read_data),
        .i_wdata (bus.req_wdata),
        .o_load  (w_load),
        .o_merge (w_merge)
    );

    assign bus.req_ready  = (r_state == ST_IDLE);
    assign bus.load_valid = r_load_valid;
    assign bus.load_data  = r_load_data;
    assign bus.misalign   = r_misalign;

    // Next state, memory strobes and register-load enables.
    always_comb begin
        w_state_nxt       = r_state;
        bus.dm_mem_read   = 1'b0;
        bus.dm_mem_write  = 1'b0;
        bus.dm_address    = w_waddr;
        bus.dm_write_data = bus.req_wdata;
        w_ld_done         = 1'b0;
        w_mis_pulse       = 1'b0;
        w_rmw             = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_acc) begin
                    if (w_mis) begin
                        w_mis_pulse = 1'b1;
                    end else if (!is_store(w_op)) begin
                        bus.dm_mem_read = 1'b1;
                        w_ld_done       = 1'b1;
                    end else if (!is_sub_word(w_op)) begin
                        bus.dm_mem_write = 1'b1;
                    end else begin
                        bus.dm_mem_read = 1'b1;
                        w_rmw           = 1'b1;
                        w_state_nxt     = ST_WB;
                    end
                end
            end
            ST_WB: begin
                bus.dm_mem_write  = !rst;
                bus.dm_address    = r_waddr;
                bus.dm_write_data = r_merge;
                w_state_nxt       = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Load result, trap pulse and RMW merge holding registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_load_valid <= 1'b0;
            r_load_data  <= 32'd0;
            r_misalign   <= 1'b0;
            r_merge      <= 32'd0;
            r_waddr      <= 32'd0;
        end else begin
            r_load_valid <= w_ld_done;
            r_misalign   <= w_mis_pulse;
            if (w_ld_done) r_load_data <= w_load;
            if (w_rmw) begin
                r_merge <= w_merge;
                r_waddr <= w_waddr;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed + random bench for mem_access_unit with a word memory model
// and a queue scoreboard of expected load results.
module tb_mem_access_unit;
    import mem_access_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic load_mem;

    logic [31:0] mem   [64];
    logic [31:0] model [64];
    logic [31:0] exp_q [$];

    int tests_run    = 0;
    int tests_failed = 0;
    int wr_count     = 0;
    bit both_seen    = 1'b0;

    mem_access_if #(.ADDR_W(32)) bus ();

    mem_access_unit #(
        .ADDR_W     (32),
        .BIG_ENDIAN (1'b0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.dm_read_data = mem[bus.dm_address[7:2]];

    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 64; i++) mem[i] <= model[i];
        end else if (bus.dm_mem_write) begin
            mem[bus.dm_address[7:2]] <= bus.dm_write_data;
            wr_count <= wr_count + 1;
        end
        if (bus.dm_mem_read && bus.dm_mem_write) both_seen <= 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h required=%h", tag, obs, exp);
        end
    endtask

    function automatic bit trap_on();
`ifdef MISALIGN_TRAP_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit misal(op_e op, logic [31:0] a);
        if (!trap_on()) return 1'b0;
        if (op == OP_LH || op == OP_LHU || op == OP_SH) return a[0];
        if (op == OP_LW || op == OP_SW) return a[1:0] != 2'b00;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(op_e op, logic [31:0] a);
        logic [31:0] w;
        logic [15:0] h;
        logic [7:0]  b;
        w = model[a[7:2]];
        h = a[1] ? w[31:16] : w[15:0];
        b = w[{a[1:0], 3'b000} +: 8];
        case (op)
            OP_LH:   return {{16{h[15]}}, h};
            OP_LHU:  return {16'd0, h};
            OP_LB:   return {{24{b[7]}}, b};
            OP_LBU:  return {24'd0, b};
            default: return w;
        endcase
    endfunction

    task automatic model_store(op_e op, logic [31:0] a, logic [31:0] d);
        case (op)
            OP_SW: model[a[7:2]] = d;
            OP_SH: begin
                if (a[1]) model[a[7:2]][31:16] = d[15:0];
                else      model[a[7:2]][15:0]  = d[15:0];
            end
            default: model[a[7:2]][{a[1:0], 3'b000} +: 8] = d[7:0];
        endcase
    endtask

    // Called just after a falling edge; returns just after the falling
    // edge that follows the accepting rising edge, with req_valid low.
    task automatic issue(input op_e op, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] exp,
                         input bit use_exp, input bit commit,
                         output int waits);
        bit ld, mis, rd, wr;
        logic [31:0] e;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        waits = 0;
        while (bus.req_ready !== 1'b1 && waits < 8) begin
            @(negedge clk);
            waits++;
        end
        if (bus.req_ready !== 1'b1) begin
            chk("accept_timeout", {31'd0, bus.req_ready}, 32'd1);
            bus.req_valid = 1'b0;
            return;
        end
        ld  = !is_store(op);
        mis = misal(op, addr);
        rd  = !mis && (ld || is_sub_word(op));
        wr  = !mis && (op == OP_SW);
        #1;
        chk("strobe_rd", {31'd0, bus.dm_mem_read}, {31'd0, rd});
        chk("strobe_wr", {31'd0, bus.dm_mem_write}, {31'd0, wr});
        if (rd || wr) chk("dm_addr", bus.dm_address, addr & ~32'd3);
        if (ld && !mis) exp_q.push_back(use_exp ? exp : model_load(op, addr));
        if (!ld && !mis && commit) model_store(op, addr, wd);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        if (ld && !mis) begin
            chk("load_valid", {31'd0, bus.load_valid}, 32'd1);
            if (bus.load_valid === 1'b1 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("load_data", bus.load_data, e);
            end
        end else begin
            chk("no_load_valid", {31'd0, bus.load_valid}, 32'd0);
        end
        if (is_sub_word(op) && !mis)
            chk("wb_ready_low", {31'd0, bus.req_ready}, 32'd0);
    endtask

    task automatic idle();
        bus.req_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int w, wc;
        op_e op;
        logic [31:0] a, saved;
        rst           = 1'b1;
        load_mem      = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_op    = OP_LW;
        bus.req_addr  = 32'd0;
        bus.req_wdata = 32'd0;
        for (int i = 0; i < 64; i++)
            model[i] = (32'(i) * 32'h0101_0101) ^ 32'hA5C3_0F96;
        model[4] = 32'h8899_AABB;
        @(negedge clk);
        @(negedge clk);
        load_mem = 1'b0;

        // reset: strobes gated even with a request present
        bus.req_valid = 1'b1;
        #1;
        chk("rst_rd", {31'd0, bus.dm_mem_read}, 32'd0);
        chk("rst_wr", {31'd0, bus.dm_mem_write}, 32'd0);
        chk("rst_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst_lv", {31'd0, bus.load_valid}, 32'd0);
        chk("rst_ld", bus.load_data, 32'd0);
        chk("rst_mis", {31'd0, bus.misalign}, 32'd0);
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // loads of 0x8899AABB
        issue(OP_LB, 32'h13, 32'd0, 32'hFFFF_FF88, 1'b1, 1'b1, w);
        issue(OP_LHU, 32'h12, 32'd0, 32'h0000_8899, 1'b1, 1'b1, w);
        issue(OP_LH, 32'h10, 32'd0, 32'hFFFF_AABB, 1'b1, 1'b1, w);
        issue(OP_LBU, 32'h11, 32'd0, 32'h0000_00AA, 1'b1, 1'b1, w);
        chk("lv_one_cycle", {31'd0, bus.load_valid}, 32'd1);
        idle();
        chk("lv_dropped", {31'd0, bus.load_valid}, 32'd0);

        // SB: one stall cycle and one write pulse
        wc = wr_count;
        issue(OP_SB, 32'h11, 32'h0000_005A, 32'd0, 1'b0, 1'b1, w);
        idle();
        chk("sb_ready_back", {31'd0, bus.req_ready}, 32'd1);
        chk("sb_wr_pulses", 32'(wr_count - wc), 32'd1);
        chk("sb_word", mem[4], 32'h8899_5ABB);

        // SB then back-to-back LW waits out the write-back
        issue(OP_SB, 32'h12, 32'h0000_1277, 32'd0, 1'b0, 1'b1, w);
        issue(OP_LW, 32'h10, 32'd0, 32'h8877_5ABB, 1'b1, 1'b1, w);
        chk("lw_waits", 32'(w), 32'd1);
        idle();

        // reset during WB of SH abandons the write
        wc    = wr_count;
        saved = model[5];
        issue(OP_SH, 32'h16, 32'h0000_BEEF, 32'd0, 1'b0, 1'b0, w);
        rst = 1'b1;
        #1;
        chk("rstwb_wr", {31'd0, bus.dm_mem_write}, 32'd0);
        chk("rstwb_ready", {31'd0, bus.req_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        chk("rstwb_mem", mem[5], saved);
        chk("rstwb_pulses", 32'(wr_count - wc), 32'd0);
        chk("rstwb_lv", {31'd0, bus.load_valid}, 32'd0);
        chk("rstwb_ld", bus.load_data, 32'd0);
        @(negedge clk);

        // misaligned LW
`ifdef MISALIGN_TRAP_EN
        issue(OP_LW, 32'h12, 32'd0, 32'd0, 1'b0, 1'b1, w);
        chk("mis_pulse", {31'd0, bus.misalign}, 32'd1);
        idle();
        chk("mis_drop", {31'd0, bus.misalign}, 32'd0);
`else
        issue(OP_LW, 32'h12, 32'd0, 32'h8877_5ABB, 1'b1, 1'b1, w);
        chk("mis_tied", {31'd0, bus.misalign}, 32'd0);
        idle();
`endif

        // random mix against the model
        for (int n = 0; n < 40; n++) begin
            op = op_e'($urandom_range(0, 7));
            a  = 32'($urandom_range(0, 63));
            if (trap_on()) begin
                if (op == OP_LW || op == OP_SW) a = a & ~32'd3;
                if (is_half(op)) a = a & ~32'd1;
            end
            issue(op, a, $urandom, 32'd0, 1'b0, 1'b1, w);
        end
        idle();
        idle();
        for (int i = 0; i < 16; i++) chk("mem_final", mem[i], model[i]);
        chk("rd_wr_excl", {31'd0, both_seen}, 32'd0);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
